// File: rtl/clkdiv_multi_if.sv
// Control and status bundle for clkdiv_multi: per-channel run/divisor requests
// in, divided clocks and status pulses out.
interface clkdiv_multi_if #(
    parameter int NCHAN = 2,
    parameter int WIDTH = 8
);
    logic [NCHAN-1:0]       enable;
    logic [NCHAN-1:0]       div_load;
    logic [NCHAN*WIDTH-1:0] div_value;
    logic [NCHAN-1:0]       clk_out;
    logic [NCHAN-1:0]       tick;
    logic [NCHAN-1:0]       pending;
    logic [NCHAN-1:0]       load_err;

    modport master (
        output enable, div_load, div_value,
        input  clk_out, tick, pending, load_err
    );

    modport slave (
        input  enable, div_load, div_value,
        output clk_out, tick, pending, load_err
    );
endinterface

// File: rtl/clkdiv_multi.sv
// Multi-channel integer clock divider; each channel swaps divisors and stops
// only on period boundaries so no clk_out phase is ever truncated.
module clkdiv_multi #(
    parameter int NCHAN       = 2,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic          CLK,
    input  logic          RST,
    clkdiv_multi_if.slave bus
);
    typedef enum logic {STOPPED, RUNNING} state_e;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        state_e           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] div_q, div_d;
        logic [WIDTH-1:0] pdiv_q, pdiv_d;
        logic             pend_q, pend_d;
        logic             clk_q, tick_q, err_q;
        logic [WIDTH-1:0] ld_val;
        logic [WIDTH:0]   half;
        logic             running, boundary, ld_ok;

        assign ld_val   = bus.div_value[g*WIDTH +: WIDTH];
        assign ld_ok    = bus.div_load[g] && (ld_val != '0);
        assign running  = (state_q == RUNNING);
        assign boundary = running && (cnt_q == div_q - 1'b1);
        assign half     = ({1'b0, div_q} + 1'b1) >> 1;

        // A load landing in the boundary cycle (or while stopped) is applied
        // on the same edge, so pending never shows for it.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            div_d   = div_q;
            pdiv_d  = pdiv_q;
            pend_d  = pend_q;
            if (ld_ok) begin
                pdiv_d = ld_val;
                pend_d = 1'b1;
            end
            if (pend_d && (!running || boundary)) begin
                div_d  = pdiv_d;
                pend_d = 1'b0;
            end
            case (state_q)
                STOPPED: begin
                    cnt_d = '0;
                    if (bus.enable[g]) state_d = RUNNING;
                end
                RUNNING: begin
                    if (boundary) begin
                        cnt_d = '0;
                        if (!bus.enable[g]) state_d = STOPPED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = STOPPED;
            endcase
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q <= STOPPED;
                cnt_q   <= '0;
                div_q   <= WIDTH'(DEFAULT_DIV);
                pdiv_q  <= '0;
                pend_q  <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                pdiv_q  <= pdiv_d;
                pend_q  <= pend_d;
                clk_q   <= running && ({1'b0, cnt_q} < half);
                tick_q  <= running && (cnt_q == '0);
                err_q   <= bus.div_load[g] && (ld_val == '0);
            end
        end

        assign bus.clk_out[g]  = clk_q;
        assign bus.tick[g]     = tick_q;
        assign bus.pending[g]  = pend_q;
        assign bus.load_err[g] = err_q;
    end
endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed and randomized bench for clkdiv_multi against a period-level
// reference model of each channel.
module tb_clkdiv_multi;
    localparam int NCHAN       = 2;
    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 4;

    logic CLK = 1'b0;
    logic RST;

    clkdiv_multi_if #(.NCHAN(NCHAN), .WIDTH(WIDTH)) bus ();

    clkdiv_multi #(
        .NCHAN(NCHAN),
        .WIDTH(WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model: running flag, position within the current period, divisors.
    bit               m_run  [NCHAN];
    int               m_pos  [NCHAN];
    int               m_D    [NCHAN];
    int               m_P    [NCHAN];
    bit               m_pend [NCHAN];
    logic [NCHAN-1:0] e_clk, e_tick, e_err, e_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] v;
        bit ld, en, bnd;
        for (int c = 0; c < NCHAN; c++) begin
            if (RST) begin
                m_run[c] = 0; m_pos[c] = 0; m_D[c] = DEFAULT_DIV; m_P[c] = 0; m_pend[c] = 0;
                e_clk[c] = 0; e_tick[c] = 0; e_err[c] = 0;
            end else begin
                v  = bus.div_value[c*WIDTH +: WIDTH];
                ld = bus.div_load[c];
                en = bus.enable[c];
                e_clk[c]  = m_run[c] && (m_pos[c] < (m_D[c] + 1) / 2);
                e_tick[c] = m_run[c] && (m_pos[c] == 0);
                e_err[c]  = ld && (v == 0);
                bnd = m_run[c] && (m_pos[c] == m_D[c] - 1);
                if (ld && v != 0) begin
                    m_P[c] = int'(v);
                    m_pend[c] = 1;
                end
                if (m_pend[c] && (!m_run[c] || bnd)) begin
                    m_D[c] = m_P[c];
                    m_pend[c] = 0;
                end
                if (!m_run[c]) begin
                    if (en) begin m_run[c] = 1; m_pos[c] = 0; end
                end else if (bnd) begin
                    m_pos[c] = 0;
                    if (!en) m_run[c] = 0;
                end else begin
                    m_pos[c]++;
                end
            end
            e_pend[c] = m_pend[c];
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
        check("clk_out",  32'(bus.clk_out),  32'(e_clk));
        check("tick",     32'(bus.tick),     32'(e_tick));
        check("pending",  32'(bus.pending),  32'(e_pend));
        check("load_err", 32'(bus.load_err), 32'(e_err));
    endtask

    task automatic load(input int ch, input int val);
        bus.div_load[ch] = 1'b1;
        bus.div_value[ch*WIDTH +: WIDTH] = WIDTH'(val);
        cyc();
        bus.div_load[ch] = 1'b0;
    endtask

    task automatic wait_tick(input int ch, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.tick[ch] && n < 64);
        check("tick_seen", 32'(bus.tick[ch]), 1);
    endtask

    task automatic capture(input int ch, input int n, output logic [15:0] pc, output logic [15:0] pt);
        pc = '0;
        pt = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) cyc();
            pc = {pc[14:0], bus.clk_out[ch]};
            pt = {pt[14:0], bus.tick[ch]};
        end
    endtask

    initial begin
        int n, k;
        logic [15:0] pc, pt;

        RST = 1'b1;
        bus.enable = '0;
        bus.div_load = '0;
        bus.div_value = '0;
        cyc();
        cyc();
        check("rst_clk_out", 32'(bus.clk_out), 0);
        check("rst_tick", 32'(bus.tick), 0);

        // D=4 on ch0: first tick two edges after enable, then 1100 repeating
        RST = 1'b0;
        bus.enable[0] = 1'b1;
        cyc();
        check("first_tick_e1", 32'(bus.tick[0]), 0);
        cyc();
        check("first_tick_e2", 32'(bus.tick[0]), 1);
        capture(0, 8, pc, pt);
        check("d4_clk", pc, 16'b11001100);
        check("d4_tick", pt, 16'b10001000);

        // Load 6 at cnt=1: current period stays 4, next is 3 high / 3 low
        wait_tick(0, n);
        load(0, 6);
        check("d6_pend_set", 32'(bus.pending[0]), 1);
        wait_tick(0, n);
        check("d4_period_kept", n, 3);
        check("d6_pend_clr", 32'(bus.pending[0]), 0);
        capture(0, 6, pc, pt);
        check("d6_clk", pc, 16'b111000);
        check("d6_tick", pt, 16'b100000);

        // ch1: D=5, then D=1, then D=2
        load(1, 5);
        check("stopped_load_pend", 32'(bus.pending[1]), 0);
        bus.enable[1] = 1'b1;
        wait_tick(1, n);
        check("ch1_start_lat", n, 2);
        capture(1, 5, pc, pt);
        check("d5_clk", pc, 16'b11100);
        check("d5_tick", pt, 16'b10000);
        load(1, 1);
        wait_tick(1, n);
        capture(1, 6, pc, pt);
        check("d1_clk", pc, 16'b111111);
        check("d1_tick", pt, 16'b111111);
        load(1, 2);
        wait_tick(1, n);
        capture(1, 6, pc, pt);
        check("d2_clk", pc, 16'b101010);
        check("d2_tick", pt, 16'b101010);

        // Zero divisor rejected; ch0 period stays 6
        load(0, 0);
        check("zero_err", 32'(bus.load_err[0]), 1);
        check("zero_pend", 32'(bus.pending[0]), 0);
        cyc();
        check("zero_err_clr", 32'(bus.load_err[0]), 0);
        wait_tick(0, n);
        wait_tick(0, n);
        check("zero_period", n, 6);

        // Load 3 in the boundary cycle takes effect immediately
        k = 0;
        while (!(m_run[0] && m_pos[0] == m_D[0] - 1) && k < 64) begin cyc(); k++; end
        load(0, 3);
        check("bnd_pend", 32'(bus.pending[0]), 0);
        wait_tick(0, n);
        check("bnd_lat", n, 1);
        capture(0, 3, pc, pt);
        check("d3_clk", pc, 16'b110);
        check("d3_tick", pt, 16'b100);

        // D=8, drop enable at cnt=0: one full period then silence
        load(0, 8);
        k = 0;
        while (!(m_run[0] && m_pos[0] == 0 && m_D[0] == 8) && k < 64) begin cyc(); k++; end
        bus.enable[0] = 1'b0;
        cyc();
        capture(0, 8, pc, pt);
        check("stop_clk", pc, 16'b11110000);
        check("stop_tick", pt, 16'b10000000);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            k += int'(bus.clk_out[0]) + int'(bus.tick[0]);
        end
        check("stopped_quiet", k, 0);

        // Reset mid-period while ch0 loads; then differing divisors
        bus.enable[0] = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        RST = 1'b1;
        bus.div_load[0] = 1'b1;
        bus.div_value[0 +: WIDTH] = WIDTH'(7);
        cyc();
        bus.div_load[0] = 1'b0;
        check("rst_mid_clk", 32'(bus.clk_out), 0);
        check("rst_mid_tick", 32'(bus.tick), 0);
        check("rst_mid_pend", 32'(bus.pending), 0);
        check("rst_mid_err", 32'(bus.load_err), 0);
        RST = 1'b0;
        load(1, 3);
        wait_tick(0, n);
        check("rst_restart_lat", n, 1);
        capture(0, 8, pc, pt);
        check("rst_default_clk", pc, 16'b11001100);
        wait_tick(1, n);
        wait_tick(1, n);
        check("ch1_indep_period", n, 3);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < NCHAN; c++) begin
                if ($urandom_range(0, 15) == 0) bus.enable[c] = ~bus.enable[c];
                bus.div_load[c] = ($urandom_range(0, 7) == 0);
                bus.div_value[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 9));
            end
            cyc();
        end
        RST = 1'b0;
        bus.div_load = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clkdiv_multi.md
CLKDIV_MULTI -- requirements
Module: clkdiv_multi

Interface
REQ-001 SHALL have parameter NCHAN, default 2, number of independent divider channels (1 to 8).
REQ-002 SHALL have parameter WIDTH, default 8, divisor width in bits (2 to 16).
REQ-003 SHALL have parameter DEFAULT_DIV, default 4, divisor every channel holds after reset (1 to 2**WIDTH-1).
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  NCHAN  per-channel run request.
REQ-007 SHALL have port div_load  input  NCHAN  per-channel one-cycle divisor write strobe.
REQ-008 SHALL have port div_value  input  NCHAN*WIDTH  divisor for channel i in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port clk_out  output  NCHAN  registered divided clock per channel.
REQ-010 SHALL have port tick  output  NCHAN  registered one-cycle pulse marking each period start.
REQ-011 SHALL have port pending  output  NCHAN  high while a loaded divisor awaits a period boundary.
REQ-012 SHALL have port load_err  output  NCHAN  one-cycle pulse when a divisor of 0 is written.

Function
REQ-013 SHALL keep per channel: active divisor D, pending divisor P, pending flag, counter cnt (WIDTH bits), and state STOPPED or RUNNING.
REQ-014 SHALL, in RUNNING, count cnt 0,1,...,D-1 and wrap to 0; cnt == D-1 is the period boundary.
REQ-015 SHALL register outputs: each edge, clk_out <= RUNNING && cnt < ceil(D/2); tick <= RUNNING && cnt == 0.
REQ-016 SHALL give a high phase of ceil(D/2) cycles and a low phase of floor(D/2) cycles; D=1 gives clk_out constantly high and tick every cycle.
REQ-017 SHALL move STOPPED -> RUNNING on the edge after enable is sampled high, with cnt = 0, so the first tick and clk_out rise appear 2 edges after enable rises.
REQ-018 SHALL, when enable is low in RUNNING, finish the current period and enter STOPPED at the boundary, with cnt = 0 and clk_out low from then on; no truncated high or low phase.
REQ-019 SHALL, on div_load with nonzero value, write P and set pending; the new value replaces any unapplied P.
REQ-020 SHALL apply P to D and clear pending at the next period boundary, or on the next edge if STOPPED.
REQ-021 SHALL apply a div_load that arrives in a boundary cycle at that boundary, so the next period uses the new divisor.
REQ-022 SHALL ignore div_load with value 0: D, P and pending stay unchanged, and load_err pulses high for one cycle.
REQ-023 SHALL, when enable drops and div_load arrives in the same boundary cycle, both stop the channel and apply the new divisor.
REQ-024 SHALL keep channels fully independent; no channel's inputs affect another channel's outputs.
REQ-025 SHALL never produce a clk_out high or low pulse shorter than floor(min(D_old, D_new)/2) cycles across a divisor change (for D=1, high runs are unbounded).

Reset
REQ-026 SHALL, while RST is high, set every channel to STOPPED with cnt = 0, D = DEFAULT_DIV, P = 0, pending = 0, clk_out = 0, tick = 0, load_err = 0.
REQ-027 SHALL give RST priority over enable and div_load in the same cycle, including mid-period.
REQ-028 SHALL resume per REQ-017 after RST falls, if enable is high.

Verification
REQ-029 SHALL cover: reset, enable ch0 with D=4 -> clk_out 1,1,0,0 repeating; tick once every 4 cycles, aligned to the first high cycle.
REQ-030 SHALL cover: D=5 -> 3 high, 2 low; D=1 -> clk_out constantly 1, tick every cycle; D=2 -> 1 high, 1 low.
REQ-031 SHALL cover: load 6 at cnt=1 while running D=4 -> pending=1 until the boundary, current period stays 4 cycles, next period is 3 high, 3 low, pending=0.
REQ-032 SHALL cover: enable dropped at cnt=0 with D=8 -> 8 more cycles of normal waveform, then clk_out held 0 and tick silent.
REQ-033 SHALL cover: div_load value 0 -> load_err pulses for 1 cycle, pending stays 0, period unchanged; load 3 in a boundary cycle -> next period is 3.
REQ-034 SHALL cover: RST asserted mid-period on ch1 while ch0 loads -> all outputs 0 on the next edge, D = DEFAULT_DIV afterwards; channels checked independent with differing divisors.
